// File: rtl/conv_output_pack.sv
// Output packer for the systolic convolution path: optional per-lane ReLU,
// FWFT output FIFO with backpressure, last-beat tagging and layer completion.
module conv_output_pack #(
    parameter int DATA_W     = 64,
    parameter int LANE_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIM_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  In_Channel,
    input  logic [DIM_W-1:0]  Matrix_Col,
    input  logic [DIM_W-1:0]  Matrix_Row,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] sData,
    input  logic              sValid,
    output logic              sReady,
    output logic [DATA_W-1:0] mData_payload,
    output logic              mData_valid,
    input  logic              mData_ready,
    output logic              mData_last,
    output logic              busy,
    output logic              layer_done,
    output logic              cfg_err
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [DIM_W-1:0] DIM_ONE  = DIM_W'(1);
    localparam logic [DIM_W-1:0] DIM_LANE = DIM_W'(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [DIM_W-1:0] r_groups;
    logic [DIM_W-1:0] r_cols;
    logic [DIM_W-1:0] r_rows;
    logic             r_relu;
    logic [DIM_W-1:0] r_grp;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] r_row;
    logic             r_layerDone;
    logic             r_cfgErr;

    logic [DATA_W:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;

    logic              w_cfgLegal;
    logic              w_startOk;
    logic              w_push;
    logic              w_pop;
    logic              w_fifoValid;
    logic              w_headLast;
    logic              w_grpWrap;
    logic              w_colWrap;
    logic              w_lastIn;
    logic [DATA_W-1:0] w_reluData;

    assign w_cfgLegal  = (In_Channel != '0) && ((In_Channel % DIM_LANE) == '0) &&
                         (Matrix_Col != '0) && (Matrix_Row != '0);
    assign w_startOk   = (r_state == S_IDLE) && start && w_cfgLegal;
    assign w_fifoValid = (r_count != '0);
    assign w_headLast  = r_mem[r_rdPtr][DATA_W];

    // sReady depends only on registered state, never on mData_ready.
    assign sReady = (r_state == S_RUN) && (r_count != CNT_FULL);
    assign w_push = sValid && sReady;
    assign w_pop  = w_fifoValid && mData_ready;

    assign w_grpWrap = (r_grp == r_groups - DIM_ONE);
    assign w_colWrap = (r_col == r_cols - DIM_ONE);
    assign w_lastIn  = w_grpWrap && w_colWrap && (r_row == r_rows - DIM_ONE);

    assign mData_valid   = w_fifoValid;
    assign mData_payload = w_fifoValid ? r_mem[r_rdPtr][DATA_W-1:0] : '0;
    assign mData_last    = w_fifoValid && w_headLast;
    assign busy          = (r_state != S_IDLE);
    assign layer_done    = r_layerDone;
    assign cfg_err       = r_cfgErr;

    always_comb begin
        w_reluData = sData;
        for (int i = 0; i < LANES; i++) begin
            if (r_relu && sData[i*LANE_W + LANE_W - 1]) begin
                w_reluData[i*LANE_W +: LANE_W] = '0;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_startOk)               w_nextState = S_RUN;
            S_RUN:   if (w_push && w_lastIn)      w_nextState = S_DRAIN;
            S_DRAIN: if (w_pop && w_headLast)     w_nextState = S_IDLE;
            default:                              w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_layerDone <= 1'b0;
            r_cfgErr    <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_layerDone <= (r_state == S_DRAIN) && w_pop && w_headLast;
            r_cfgErr    <= (r_state == S_IDLE) && start && !w_cfgLegal;
        end
    end

    // Geometry is latched on an accepted start; counters nest grp, col, row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_groups <= '0;
            r_cols   <= '0;
            r_rows   <= '0;
            r_relu   <= 1'b0;
            r_grp    <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_startOk) begin
            r_groups <= In_Channel / DIM_LANE;
            r_cols   <= Matrix_Col;
            r_rows   <= Matrix_Row;
            r_relu   <= relu_en;
            r_grp    <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_push) begin
            if (w_grpWrap) begin
                r_grp <= '0;
                if (w_colWrap) begin
                    r_col <= '0;
                    r_row <= w_lastIn ? '0 : r_row + DIM_ONE;
                end else begin
                    r_col <= r_col + DIM_ONE;
                end
            end else begin
                r_grp <= r_grp + DIM_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {w_lastIn, w_reluData};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_output_pack.sv
// Scoreboard bench for conv_output_pack: the driver queues expected beats,
// a monitor thread pops and compares them whenever the DUT hands one off.
module tb_conv_output_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] In_Channel;
    logic [15:0] Matrix_Col;
    logic [15:0] Matrix_Row;
    logic        relu_en;
    logic [63:0] sData;
    logic        sValid;
    logic        sReady;
    logic [63:0] mData_payload;
    logic        mData_valid;
    logic        mData_ready = 1'b0;
    logic        mData_last;
    logic        busy;
    logic        layer_done;
    logic        cfg_err;

    int          checks   = 0;
    int          failures = 0;
    int          accCount = 0;
    int          doneCount = 0;
    int          expLayers = 0;
    int          rdyMode  = 1;
    logic [64:0] expQ [$];

    conv_output_pack dut (
        .clk(clk), .reset(reset), .start(start),
        .In_Channel(In_Channel), .Matrix_Col(Matrix_Col), .Matrix_Row(Matrix_Row),
        .relu_en(relu_en), .sData(sData), .sValid(sValid), .sReady(sReady),
        .mData_payload(mData_payload), .mData_valid(mData_valid),
        .mData_ready(mData_ready), .mData_last(mData_last),
        .busy(busy), .layer_done(layer_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beatData(input int tag, input int i);
        logic [15:0] t16;
        logic [15:0] i16;
        t16 = 16'(tag);
        i16 = 16'(i);
        return {t16, i16, ~i16, 16'(i * 3)};
    endfunction

    // Offer one beat until the DUT takes it; the expected entry is queued at acceptance.
    task automatic sendOne(input logic [63:0] d, input logic [63:0] e, input bit last, input bit gaps);
        int  n;
        bit  taken;
        n = 0;
        taken = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            sValid = 1'b0;
            @(posedge clk); #1;
        end
        sData  = d;
        sValid = 1'b1;
        while (!taken && n < 2000) begin
            @(negedge clk);
            if (sReady) begin
                expQ.push_back({last, e});
                accCount++;
                taken = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        sValid = 1'b0;
        if (!taken) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic applyStimulus(input int first, input int n, input int total, input int tag, input bit gaps);
        logic [63:0] d;
        for (int i = first; i < first + n; i++) begin
            d = beatData(tag, i);
            sendOne(d, d, (i == total - 1), gaps);
        end
    endtask

    task automatic startLayer(input int ch, input int col, input int row, input bit relu);
        start = 1'b1;
        In_Channel = 16'(ch);
        Matrix_Col = 16'(col);
        Matrix_Row = 16'(row);
        relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
        In_Channel = 16'hDEAD;
        Matrix_Col = 16'd0;
        Matrix_Row = 16'd0;
        relu_en = ~relu;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_sready", sReady, 1);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((busy || expQ.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 64'(busy || expQ.size() != 0), 0);
        expLayers++;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!layer_done && n < budget);
        checkOutput("done_timeout", layer_done, 1);
        expLayers++;
    endtask

    task automatic illegalStart(input int ch, input int col, input int row);
        start = 1'b1;
        In_Channel = 16'(ch);
        Matrix_Col = 16'(col);
        Matrix_Row = 16'(row);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("cfg_err_pulse", cfg_err, 1);
        checkOutput("cfg_err_busy", busy, 0);
        checkOutput("cfg_err_sready", sReady, 0);
        @(posedge clk); #1;
        checkOutput("cfg_err_clear", cfg_err, 0);
        checkOutput("cfg_err_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sValid = 1'b0; sData = '0;
        In_Channel = '0; Matrix_Col = '0; Matrix_Row = '0; relu_en = 1'b0;
        fork
            // Main stimulus sequence.
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                checkOutput("rst_sready", sReady, 0);
                checkOutput("rst_valid", mData_valid, 0);
                checkOutput("rst_last", mData_last, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_done", layer_done, 0);
                checkOutput("rst_cfgerr", cfg_err, 0);
                checkOutput("rst_payload", mData_payload, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                @(posedge clk); #1;

                startLayer(32, 14, 14, 0);
                applyStimulus(0, 784, 784, 1, 0);
                waitIdle(200);

                rdyMode = 0;
                @(posedge clk); #1;
                accCount = 0;
                startLayer(32, 14, 14, 0);
                fork
                    applyStimulus(0, 784, 784, 2, 0);
                    begin
                        repeat (40) @(negedge clk);
                        checkOutput("bp_accepted", 64'(accCount), 16);
                        checkOutput("bp_sready", sReady, 0);
                        rdyMode = 1;
                    end
                join
                waitIdle(200);

                rdyMode = 2;
                startLayer(32, 14, 14, 0);
                applyStimulus(0, 784, 784, 3, 1);
                waitIdle(400);
                rdyMode = 1;

                startLayer(8, 1, 2, 1);
                sendOne(64'hFF017F8000000102, 64'h00017F0000000102, 0, 0);
                sendOne(64'h8081FE7F00FF1020, 64'h0000007F00001020, 1, 0);
                waitIdle(50);
                startLayer(8, 1, 1, 0);
                sendOne(64'hFF017F8000000102, 64'hFF017F8000000102, 1, 0);
                waitIdle(50);

                @(posedge clk); #1;
                illegalStart(12, 1, 1);
                illegalStart(0, 1, 1);
                illegalStart(8, 0, 1);
                illegalStart(8, 1, 0);
                startLayer(8, 1, 1, 0);
                sendOne(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1, 0);
                waitIdle(50);

                @(posedge clk); #1;
                startLayer(32, 14, 14, 0);
                applyStimulus(0, 100, 784, 4, 0);
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                checkOutput("midrst_valid", mData_valid, 0);
                checkOutput("midrst_busy", busy, 0);
                checkOutput("midrst_sready", sReady, 0);
                expQ.delete();
                repeat (5) @(posedge clk); #1;
                startLayer(32, 14, 14, 0);
                applyStimulus(0, 784, 784, 5, 0);
                waitIdle(200);

                @(posedge clk); #1;
                startLayer(8, 2, 3, 0);
                applyStimulus(0, 3, 6, 6, 0);
                start = 1'b1; In_Channel = 16'd8; Matrix_Col = 16'd1; Matrix_Row = 16'd1;
                @(posedge clk); #1;
                start = 1'b0;
                checkOutput("busy_start_ignored", busy, 1);
                applyStimulus(3, 3, 6, 6, 0);
                waitDone(100);
                startLayer(16, 2, 2, 0);
                applyStimulus(0, 8, 8, 7, 0);
                waitIdle(100);

                repeat (4) @(negedge clk);
                checkOutput("layer_done_count", 64'(doneCount), 64'(expLayers));
                checkOutput("final_busy", busy, 0);
            end
            // Monitor: layer_done timing, hold stability, scoreboard compare.
            begin
                bit          expectDone;
                bit          heldValid;
                logic [64:0] held;
                logic [64:0] exp;
                expectDone = 1'b0;
                heldValid  = 1'b0;
                held       = '0;
                forever begin
                    @(negedge clk);
                    if (layer_done) doneCount++;
                    if (expectDone) begin
                        checkOutput("layer_done_pulse", layer_done, 1);
                        checkOutput("busy_after_done", busy, 0);
                        expectDone = 1'b0;
                    end else if (layer_done) begin
                        checkOutput("spurious_layer_done", layer_done, 0);
                    end
                    if (heldValid && mData_valid)
                        checkOutput("hold_stable", 64'(held != {mData_last, mData_payload}), 0);
                    heldValid = mData_valid && !mData_ready;
                    held = {mData_last, mData_payload};
                    if (mData_valid && mData_ready) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected_beat", mData_payload, 0);
                        end else begin
                            exp = expQ.pop_front();
                            checkOutput("beat_payload", mData_payload, exp[63:0]);
                            checkOutput("beat_last", mData_last, 64'(exp[64]));
                        end
                        if (mData_last && !reset) expectDone = 1'b1;
                    end
                end
            end
            // Output-side ready generator.
            begin
                forever begin
                    @(posedge clk); #1;
                    case (rdyMode)
                        0:       mData_ready = 1'b0;
                        1:       mData_ready = 1'b1;
                        default: mData_ready = 1'($urandom_range(0, 1));
                    endcase
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
